// File: rtl/truth_table_scanner_pkg.sv
// tt_pkg: shared state encoding, golden table default and settle counter width.
package tt_pkg;
    localparam int CNT_W = 4;
    localparam logic [7:0] EXPECTED_DEFAULT = 8'h35;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: stimulus/capture bundle between the scanner (master) and the block under scan.
interface truth_table_scanner_if #(parameter int N_IN = 3);
    logic start, f_in, busy, done, pass, mismatch_valid;
    logic [N_IN-1:0] abc, mismatch_idx;
    logic [2**N_IN-1:0] table_out;
    modport master(input start, f_in, output abc, busy, done, table_out, pass, mismatch_valid, mismatch_idx);
    modport slave(output start, f_in, input abc, busy, done, table_out, pass, mismatch_valid, mismatch_idx);
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it.
module settle_timer
    import tt_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk)
        cnt <= rst ? '0 : load ? load_val : zero ? cnt : cnt - 1'b1;
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks abc through every input vector, captures F and checks it against EXPECTED.
// Optional SCAN_MISMATCH_EN builds the lowest-differing-index encoder; otherwise mismatch ports read 0.
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECTED = EXPECTED_DEFAULT
) (
    input logic clk,
    input logic rst,
    truth_table_scanner_if.master bus
);
    localparam int T = 2**N_IN;
    localparam logic [N_IN-1:0] LAST = N_IN'(T - 1);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

    state_e state;
    logic [N_IN-1:0] idx;
    logic [T-1:0] shadow, sampled, table_q;
    logic pass_q, zero, sample, last, load;

    assign sample = state == WAIT && zero;
    assign last = idx == LAST;
    assign load = (state == IDLE && bus.start) || (sample && !last);

    settle_timer #(.W(CNT_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(SETTLE_V),
        .zero(zero)
    );

    // the final sample must land in table_out on the same edge it is taken
    always_comb begin
        sampled = shadow;
        sampled[idx] = bus.f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            shadow <= '0;
            table_q <= '0;
            pass_q <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                state <= WAIT;
                idx <= '0;
                shadow <= '0;
            end
        end else if (state == WAIT) begin
            if (zero) begin
                shadow <= sampled;
                idx <= last ? '0 : idx + 1'b1;
                if (last) begin
                    state <= DONE;
                    table_q <= sampled;
                    pass_q <= sampled == EXPECTED;
                end
            end
        end else begin
            state <= IDLE;
        end
    end

    assign bus.abc = idx;
    assign bus.busy = state == WAIT;
    assign bus.done = state == DONE;
    assign bus.table_out = table_q;
    assign bus.pass = pass_q;

`ifdef SCAN_MISMATCH_EN
    logic [T-1:0] diff;
    logic [N_IN-1:0] first;
    logic mv_q;
    logic [N_IN-1:0] mi_q;
    assign diff = sampled ^ EXPECTED;
    always_comb begin
        first = '0;
        for (int i = T - 1; i >= 0; i--)
            if (diff[i]) first = N_IN'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_q <= 1'b0;
            mi_q <= '0;
        end else if (sample && last) begin
            mv_q <= |diff;
            mi_q <= first;
        end
    end
    assign bus.mismatch_valid = mv_q;
    assign bus.mismatch_idx = mi_q;
`else
    assign bus.mismatch_valid = 1'b0;
    assign bus.mismatch_idx = '0;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench for the scanner (SETTLE=1) plus a SETTLE=0 instance.
module tb_truth_table_scanner;
    localparam int S = 1;
    localparam int W = 8 * (S + 1);

    typedef struct {
        logic [7:0] tbl;
        logic pass, mv;
        logic [2:0] mi;
        int cyc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, faulty = 1'b0;
    int total = 0, bad = 0, cyc = 0, rem = 0, prev_done = 0, last_done = 0;
    exp_t q[$];
    exp_t held = '{tbl: 8'h00, pass: 1'b0, mv: 1'b0, mi: 3'd0, cyc: 0};

    truth_table_scanner_if #(.N_IN(3)) if0 ();
    truth_table_scanner_if #(.N_IN(3)) if1 ();

    truth_table_scanner #(.N_IN(3), .SETTLE(S)) u0 (.clk(clk), .rst(rst), .bus(if0));
    truth_table_scanner #(.N_IN(3), .SETTLE(0)) u1 (.clk(clk), .rst(rst), .bus(if1));

    // SoP under test: F = ~A~C + A~B ; faulty variant drops the A~B term
    assign if0.f_in = faulty ? (~if0.abc[2] & ~if0.abc[0])
                             : ((~if0.abc[2] & ~if0.abc[0]) | (if0.abc[2] & ~if0.abc[1]));
    assign if1.f_in = (~if1.abc[2] & ~if1.abc[0]) | (if1.abc[2] & ~if1.abc[1]);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // reference model: acceptance, scan length and expected result per scan
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            rem = 0;
            q.delete();
            held = '{tbl: 8'h00, pass: 1'b0, mv: 1'b0, mi: 3'd0, cyc: 0};
        end else if (rem == 0 && if0.start) begin
            e.tbl = faulty ? 8'h05 : 8'h35;
            e.pass = !faulty;
`ifdef SCAN_MISMATCH_EN
            e.mv = faulty;
            e.mi = faulty ? 3'd4 : 3'd0;
`else
            e.mv = 1'b0;
            e.mi = 3'd0;
`endif
            e.cyc = cyc + W;
            q.push_back(e);
            rem = W + 1;
        end else if (rem > 0) begin
            rem--;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            chk("busy", 32'(if0.busy), 32'(rem > 1));
            chk("done", 32'(if0.done), 32'(rem == 1));
            chk("abc", 32'(if0.abc), rem > 1 ? 32'((W + 1 - rem) / (S + 1)) : 32'd0);
            if (if0.done) begin
                chk("sb_size", 32'(q.size()), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("done_cyc", 32'(cyc), 32'(e.cyc));
                    held = e;
                    prev_done = last_done;
                    last_done = cyc;
                end
            end
            chk("table_out", 32'(if0.table_out), 32'(held.tbl));
            chk("pass", 32'(if0.pass), 32'(held.pass));
            chk("mm_valid", 32'(if0.mismatch_valid), 32'(held.mv));
            chk("mm_idx", 32'(if0.mismatch_idx), 32'(held.mi));
        end
    end

    task automatic pulse();
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse();
        repeat (20) @(negedge clk);
        faulty = 1'b1;
        pulse();
        repeat (20) @(negedge clk);
        faulty = 1'b0;
        pulse();
        repeat (4) @(negedge clk);
        pulse();
        repeat (20) @(negedge clk);
        if0.start = 1'b1;
        repeat (36) @(negedge clk);
        if0.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("period", 32'(last_done - prev_done), 32'(W + 2));
        pulse();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse();
        repeat (20) @(negedge clk);
        chk("sb_left", 32'(q.size()), 32'd0);
        if1.start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if1.start = 1'b0;
            chk("s0_abc", 32'(if1.abc), k < 8 ? 32'(k) : 32'd0);
            chk("s0_busy", 32'(if1.busy), 32'(k < 8));
            chk("s0_done", 32'(if1.done), 32'(k == 8));
            if (k == 8) begin
                chk("s0_table", 32'(if1.table_out), 32'h35);
                chk("s0_pass", 32'(if1.pass), 32'd1);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture stage placed directly upstream of the 3-input sum-of-products block. It drives the block's inputs A, B, C through every combination 0..2^N_IN-1 and waits a programmable settle time per vector. It samples the block's output F back into a truth-table vector and compares the result against an expected minterm mask. It gives the combinational function a clocked, self-checking harness that can be instantiated on-chip or in a bench.

## Interface
Parameters:
- N_IN, 3, number of function inputs; table width is 2^N_IN
- SETTLE, 1, extra hold cycles per vector before sampling (0..15)
- EXPECTED, 8'h35, golden table; bit k = F for {A,B,C}=k (minterms 0,2,4,5)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  scan request; accepted only in IDLE
- abc  out  N_IN  vector driven to the SoP block, MSB = A
- f_in  in  1  F returned from the SoP block
- busy  out  1  high while vectors are being driven
- done  out  1  one-cycle pulse when the result is valid
- table_out  out  2^N_IN  last captured truth table
- pass  out  1  table_out == EXPECTED, valid from done
- mismatch_valid  out  1  at least one bit differs (SCAN_MISMATCH_EN)
- mismatch_idx  out  N_IN  lowest differing index (SCAN_MISMATCH_EN)

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - start=1 → WAIT, index=0, abc=0, settle counter=SETTLE, shadow table cleared.
  - start=0 → stay in IDLE.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is zero, write f_in into shadow[index].
  - If index is not the last vector, increment index, set abc=index+1, reload the counter to SETTLE.
  - If index = 2^N_IN-1, go to DONE. Copy shadow (including the sample just taken) to table_out and compute pass and the mismatch outputs.
- DONE: done=1 for one cycle, abc=0, then unconditionally IDLE.
- start is ignored in WAIT and DONE. It is not queued.
- table_out, pass and the mismatch outputs hold their value until the next DONE or rst. They do not change during a scan.
- f_in is treated as synchronous. It must be settled within SETTLE+1 cycles of abc changing, with no synchroniser.
- mismatch_idx is from a priority encoder on table_out ^ EXPECTED, scanning from index 0 upward.

## Timing
- Reset values:
  - state=IDLE
  - abc=0
  - busy=0
  - done=0
  - table_out=0
  - pass=0
  - mismatch_valid=0
  - mismatch_idx=0
- rst mid-scan aborts immediately, with no done pulse, and all outputs go to reset values.
- Edge E0 samples start=1 in IDLE. From E0, busy=1 and abc=0.
- Each vector is held for exactly SETTLE+1 cycles. f_in is sampled on the edge that ends the vector's last cycle.
- The last sample is taken at E0 + 2^N_IN·(SETTLE+1). At that edge busy falls and done rises for one cycle, with results valid in the same cycle.
- With default parameters, done is high in the cycle after edge E0+16.
- If start is held high, back-to-back scans have a period of 2^N_IN·(SETTLE+1)+2 cycles (18 for defaults).

## Configuration
- SCAN_MISMATCH_EN defined: the priority encoder is built, and mismatch_valid and mismatch_idx update at DONE.
- SCAN_MISMATCH_EN undefined: the encoder is omitted and both ports are tied to 0. The port list is unchanged and pass is still produced.

## Structure
- Package tt_pkg holds:
  - the state enum (IDLE, WAIT, DONE)
  - the default EXPECTED constant 8'h35
  - the SETTLE counter width of 4 bits
- Sub-module settle_timer holds the loadable down-counter with load and zero flag. The FSM, shadow register and compare stay in truth_table_scanner.

## Test plan
- Reset: assert rst for 2 cycles → abc=0, busy=0, done=0, table_out=0, pass=0.
- Golden scan: f_in wired to the SoP of abc, pulse start → abc steps 0..7 every 2 cycles. done appears after edge E0+16 with table_out=8'h35, pass=1, mismatch_valid=0.
- Faulty function: f_in = ~A & ~C → table_out=8'h05, pass=0, mismatch_valid=1, mismatch_idx=4 (with macro), or 0/0 without the macro.
- Start while busy: pulse start at E0+5 → ignored, single done. start held high → done pulses 18 cycles apart.
- Reset mid-scan: rst at E0+8 → abc=0, busy=0, no done, table_out=0. A new start gives a clean full scan.
- SETTLE=0 build: golden f_in → abc changes every cycle, done after edge E0+8, table_out=8'h35.
